csr_file: RTL and testbench

Machine-mode CSR storage that consumes the execute stage's flopped CSR write-back and exception outputs. Holds the trap registers, scratch register and 64-bit cycle/instret counters. Feeds mepc/mtvec/mstatus back to execute. Provides a combinational read port used by decode to source CSR operands.

---
 rtl/csr_file_pkg.sv | 61 ++++++
 rtl/csr_file_counter64.sv | 44 ++++
 rtl/csr_file.sv | 165 ++++++++++++++++
 tb/tb_csr_file.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, mstatus
// field positions, write mask and small helper functions.
package csr_file_pkg;

    localparam int CSR_XLEN = 32;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // User-mode read-only counter aliases
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    // Only MIE, MPIE and MPP are implemented; everything else reads zero
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_1888;
    // Reset state: MPP = M-mode, interrupts disabled
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    // Result of a read-port decode
    typedef struct packed {
        logic        illegal;
        logic [31:0] data;
    } csr_rd_t;

    // Clear the two low bits (direct-mode mtvec, 4-byte aligned mepc)
    function automatic logic [31:0] align4(input logic [31:0] val);
        return val & ~32'd3;
    endfunction

    // mstatus after a trap: stash MIE in MPIE, disable interrupts,
    // record the privilege mode the trap came from
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms,
                                                 input logic [1:0]  mode);
        logic [31:0] r;
        r                                = 32'd0;
        r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mode;
        return r;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half suppresses that cycle's increment and leaves the
// other half untouched.
module csr_counter64
    import csr_file_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_q_o
);

    logic [63:0] cnt_d;
    logic [63:0] cnt_q;

    // Next count: a write takes priority over the increment
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d = {cnt_q[63:32], wdata_i};
        end else if (wr_hi_i) begin
            cnt_d = {wdata_i, cnt_q[31:0]};
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_q_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap registers, mscratch, mcycle/minstret and a
// combinational read port for decode.
// Optional build macro ZICNTR_USER_EN: also decode the read-only user
// counter aliases cycle/instret/cycleh/instreth.
module csr_file
    import csr_file_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] HART_ID  = 32'd0,
    parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_wbk_v_i,
    input  logic [11:0]     csr_adr_i,
    input  logic [XLEN-1:0] csr_data_i,
    input  logic            exception_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] mtval_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [1:0]      core_mode_i,
    input  logic            retire_i,
    input  logic [11:0]     rd_adr_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_illegal_o,
    output logic [XLEN-1:0] mstatus_q_o,
    output logic [XLEN-1:0] mtvec_q_o,
    output logic [XLEN-1:0] mepc_q_o
);

    logic [XLEN-1:0] mstatus_d,  mstatus_q;
    logic [XLEN-1:0] mtvec_d,    mtvec_q;
    logic [XLEN-1:0] mscratch_d, mscratch_q;
    logic [XLEN-1:0] mepc_d,     mepc_q;
    logic [XLEN-1:0] mcause_d,   mcause_q;
    logic [XLEN-1:0] mtval_d,    mtval_q;

    logic [63:0] mcycle_s;
    logic [63:0] minstret_s;
    logic        wr_mcycle_lo_s;
    logic        wr_mcycle_hi_s;
    logic        wr_minstret_lo_s;
    logic        wr_minstret_hi_s;
    csr_rd_t     rd_s;

    // Counter half write strobes; a trap does not block counter writes
    always_comb begin
        wr_mcycle_lo_s   = csr_wbk_v_i && (csr_adr_i == CSR_MCYCLE);
        wr_mcycle_hi_s   = csr_wbk_v_i && (csr_adr_i == CSR_MCYCLEH);
        wr_minstret_lo_s = csr_wbk_v_i && (csr_adr_i == CSR_MINSTRET);
        wr_minstret_hi_s = csr_wbk_v_i && (csr_adr_i == CSR_MINSTRETH);
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (1'b1),
        .wr_lo_i (wr_mcycle_lo_s),
        .wr_hi_i (wr_mcycle_hi_s),
        .wdata_i (csr_data_i),
        .cnt_q_o (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (retire_i),
        .wr_lo_i (wr_minstret_lo_s),
        .wr_hi_i (wr_minstret_hi_s),
        .wdata_i (csr_data_i),
        .cnt_q_o (minstret_s)
    );

    // Next-state for the trap/scratch registers: CSR write first, then the
    // trap overrides the registers it owns (mepc, mcause, mtval, mstatus)
    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (csr_wbk_v_i) begin
            case (csr_adr_i)
                CSR_MSTATUS:  mstatus_d  = csr_data_i & MSTATUS_WMASK;
                CSR_MTVEC:    mtvec_d    = align4(csr_data_i);
                CSR_MSCRATCH: mscratch_d = csr_data_i;
                CSR_MEPC:     mepc_d     = align4(csr_data_i);
                CSR_MCAUSE:   mcause_d   = csr_data_i;
                CSR_MTVAL:    mtval_d    = csr_data_i;
                // Counters are handled in csr_counter64; read-only and
                // unimplemented addresses drop the write
                default: ;
            endcase
        end else begin
            mscratch_d = mscratch_q;
        end

        if (exception_i) begin
            mepc_d    = align4(mepc_i);
            mcause_d  = mcause_i;
            mtval_d   = mtval_i;
            mstatus_d = trap_mstatus(mstatus_q, core_mode_i);
        end else begin
            mtval_d = mtval_d;
        end
    end

    // Trap/scratch register state with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_q  <= MSTATUS_RESET;
            mtvec_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    // Combinational read decode; unimplemented addresses return zero
    always_comb begin
        rd_s.illegal = 1'b0;
        rd_s.data    = 32'd0;
        case (rd_adr_i)
            CSR_MSTATUS:   rd_s.data = mstatus_q;
            CSR_MISA:      rd_s.data = MISA_VAL;
            CSR_MTVEC:     rd_s.data = mtvec_q;
            CSR_MSCRATCH:  rd_s.data = mscratch_q;
            CSR_MEPC:      rd_s.data = mepc_q;
            CSR_MCAUSE:    rd_s.data = mcause_q;
            CSR_MTVAL:     rd_s.data = mtval_q;
            CSR_MCYCLE:    rd_s.data = mcycle_s[31:0];
            CSR_MINSTRET:  rd_s.data = minstret_s[31:0];
            CSR_MCYCLEH:   rd_s.data = mcycle_s[63:32];
            CSR_MINSTRETH: rd_s.data = minstret_s[63:32];
            CSR_MHARTID:   rd_s.data = HART_ID;
`ifdef ZICNTR_USER_EN
            CSR_CYCLE:     rd_s.data = mcycle_s[31:0];
            CSR_INSTRET:   rd_s.data = minstret_s[31:0];
            CSR_CYCLEH:    rd_s.data = mcycle_s[63:32];
            CSR_INSTRETH:  rd_s.data = minstret_s[63:32];
`endif
            default: begin
                rd_s.illegal = 1'b1;
                rd_s.data    = 32'd0;
            end
        endcase
    end

    assign rd_data_o    = rd_s.data;
    assign rd_illegal_o = rd_s.illegal;
    assign mstatus_q_o  = mstatus_q;
    assign mtvec_q_o    = mtvec_q;
    assign mepc_q_o     = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: reset checks, a table of single-write
// vectors, hand-written trap/counter sequences and randomized traffic
// compared against a field-level behavioural model.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_wbk_v_i;
    logic [11:0] csr_adr_i;
    logic [31:0] csr_data_i;
    logic        exception_i;
    logic [31:0] mcause_i;
    logic [31:0] mtval_i;
    logic [31:0] mepc_i;
    logic [1:0]  core_mode_i;
    logic        retire_i;
    logic [11:0] rd_adr_i;
    logic [31:0] rd_data_o;
    logic        rd_illegal_o;
    logic [31:0] mstatus_q_o;
    logic [31:0] mtvec_q_o;
    logic [31:0] mepc_q_o;

    int n_chk  = 0;
    int n_fail = 0;

    csr_file dut (
        .clk          (clk),
        .reset        (reset),
        .csr_wbk_v_i  (csr_wbk_v_i),
        .csr_adr_i    (csr_adr_i),
        .csr_data_i   (csr_data_i),
        .exception_i  (exception_i),
        .mcause_i     (mcause_i),
        .mtval_i      (mtval_i),
        .mepc_i       (mepc_i),
        .core_mode_i  (core_mode_i),
        .retire_i     (retire_i),
        .rd_adr_i     (rd_adr_i),
        .rd_data_o    (rd_data_o),
        .rd_illegal_o (rd_illegal_o),
        .mstatus_q_o  (mstatus_q_o),
        .mtvec_q_o    (mtvec_q_o),
        .mepc_q_o     (mepc_q_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (field level) ----------------
    longint unsigned m_cyc, m_ins;
    logic [31:0] m_mtvec, m_scr, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;
    logic [1:0]  m_mpp;

    function automatic void m_reset();
        m_cyc = 0; m_ins = 0;
        m_mtvec = 32'd0; m_scr = 32'd0; m_mepc = 32'd0;
        m_mcause = 32'd0; m_mtval = 32'd0;
        m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b11;
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void m_update();
        longint unsigned n_cyc, n_ins;
        longint unsigned hi_mask;
        logic old_mie;
        hi_mask = 64'hFFFF_FFFF_0000_0000;
        old_mie = m_mie;
        n_cyc = m_cyc + 1;
        n_ins = m_ins + (retire_i ? 1 : 0);
        if (csr_wbk_v_i) begin
            case (csr_adr_i)
                12'h300: begin
                    m_mie  = csr_data_i[3];
                    m_mpie = csr_data_i[7];
                    m_mpp  = csr_data_i[12:11];
                end
                12'h305: m_mtvec  = csr_data_i & ~32'd3;
                12'h340: m_scr    = csr_data_i;
                12'h341: m_mepc   = csr_data_i & ~32'd3;
                12'h342: m_mcause = csr_data_i;
                12'h343: m_mtval  = csr_data_i;
                12'hB00: n_cyc = (m_cyc & hi_mask) | 64'(csr_data_i);
                12'hB80: n_cyc = (64'(csr_data_i) << 32) | (m_cyc & ~hi_mask);
                12'hB02: n_ins = (m_ins & hi_mask) | 64'(csr_data_i);
                12'hB82: n_ins = (64'(csr_data_i) << 32) | (m_ins & ~hi_mask);
                default: ;
            endcase
        end
        if (exception_i) begin
            m_mepc   = mepc_i & ~32'd3;
            m_mcause = mcause_i;
            m_mtval  = mtval_i;
            m_mpie   = old_mie;
            m_mie    = 1'b0;
            m_mpp    = core_mode_i;
        end
        m_cyc = n_cyc;
        m_ins = n_ins;
    endfunction

    function automatic void m_read(input logic [11:0] a,
                                   output logic [31:0] d, output logic ill);
        ill = 1'b0;
        case (a)
            12'h300: d = m_status();
            12'h301: d = 32'h4000_0100;
            12'h305: d = m_mtvec;
            12'h340: d = m_scr;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h343: d = m_mtval;
            12'hB00: d = m_cyc[31:0];
            12'hB80: d = m_cyc[63:32];
            12'hB02: d = m_ins[31:0];
            12'hB82: d = m_ins[63:32];
            12'hF14: d = 32'd0;
`ifdef ZICNTR_USER_EN
            12'hC00: d = m_cyc[31:0];
            12'hC80: d = m_cyc[63:32];
            12'hC02: d = m_ins[31:0];
            12'hC82: d = m_ins[63:32];
`endif
            default: begin d = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle_inputs();
        csr_wbk_v_i = 1'b0; csr_adr_i = 12'h000; csr_data_i = 32'd0;
        exception_i = 1'b0; mcause_i = 32'd0; mtval_i = 32'd0;
        mepc_i = 32'd0; core_mode_i = 2'b00; retire_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wbk_v_i = 1'b1; csr_adr_i = a; csr_data_i = d;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a,
                          input logic [31:0] exp_d, input logic exp_ill);
        rd_adr_i = a;
        #1;
        chk({name, ".data"}, rd_data_o, exp_d);
        chk({name, ".ill"}, 32'(rd_illegal_o), 32'(exp_ill));
    endtask

    // Compare q outputs and one read address against the model
    task automatic model_chk(input string name, input logic [11:0] a);
        logic [31:0] d;
        logic        ill;
        chk({name, ".mstatus"}, mstatus_q_o, m_status());
        chk({name, ".mtvec"}, mtvec_q_o, m_mtvec);
        chk({name, ".mepc"}, mepc_q_o, m_mepc);
        m_read(a, d, ill);
        rd_chk(name, a, d, ill);
    endtask

    typedef struct {
        logic [11:0] wadr;
        logic [31:0] wdata;
        logic [11:0] radr;
        logic [31:0] exp_d;
        logic        exp_ill;
    } vec_t;

    vec_t        vecs[10];
    logic [11:0] adr_pool[20];

    initial begin
        vecs[0] = '{12'h305, 32'h8000_0103, 12'h305, 32'h8000_0100, 1'b0};
        vecs[1] = '{12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b0};
        vecs[2] = '{12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{12'h341, 32'h0000_1003, 12'h341, 32'h0000_1000, 1'b0};
        vecs[4] = '{12'h342, 32'h8000_0007, 12'h342, 32'h8000_0007, 1'b0};
        vecs[5] = '{12'h343, 32'h1234_5678, 12'h343, 32'h1234_5678, 1'b0};
        vecs[6] = '{12'h301, 32'h0000_0000, 12'h301, 32'h4000_0100, 1'b0};
        vecs[7] = '{12'hF14, 32'hFFFF_FFFF, 12'hF14, 32'h0000_0000, 1'b0};
        vecs[8] = '{12'h7C0, 32'hFFFF_FFFF, 12'h7C0, 32'h0000_0000, 1'b1};
        vecs[9] = '{12'h300, 32'h0000_0008, 12'h300, 32'h0000_0008, 1'b0};

        adr_pool = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                     12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14,
                     12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h000,
                     12'hFFF, 12'h344};

        idle_inputs();
        rd_adr_i = 12'h300;
        reset = 1'b1;
        m_reset();
        #2;
        chk("rst.mstatus", mstatus_q_o, 32'h0000_1800);
        chk("rst.mtvec", mtvec_q_o, 32'd0);
        chk("rst.mepc", mepc_q_o, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rd_chk("rst.mcycle5", 12'hB00, 32'd5, 1'b0);
        rd_chk("rst.minstret0", 12'hB02, 32'd0, 1'b0);
        chk("rst.mstatus5", mstatus_q_o, 32'h0000_1800);

        // Table of single-write vectors
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].wadr, vecs[i].wdata);
            cycle();
            idle_inputs();
            rd_chk($sformatf("vec%0d", i), vecs[i].radr, vecs[i].exp_d, vecs[i].exp_ill);
            if (i == 0) chk("vec0.mtvec_q", mtvec_q_o, 32'h8000_0100);
            chk($sformatf("vec%0d.mstatus_model", i), mstatus_q_o, m_status());
        end

        // Trap with MIE=1 from M-mode
        exception_i = 1'b1; mepc_i = 32'h0000_0206; mcause_i = 32'd11;
        mtval_i = 32'h0000_0055; core_mode_i = 2'b11;
        cycle();
        idle_inputs();
        chk("trap.mepc", mepc_q_o, 32'h0000_0204);
        chk("trap.mstatus", mstatus_q_o, 32'h0000_1880);
        rd_chk("trap.mcause", 12'h342, 32'd11, 1'b0);
        rd_chk("trap.mtval", 12'h343, 32'h0000_0055, 1'b0);

        // Trap and mepc write in the same cycle: trap wins
        exception_i = 1'b1; mepc_i = 32'h0000_0306; mcause_i = 32'd2;
        core_mode_i = 2'b00; wr(12'h341, 32'h0000_1000);
        cycle();
        idle_inputs();
        chk("trapwr.mepc", mepc_q_o, 32'h0000_0304);
        chk("trapwr.mstatus", mstatus_q_o, 32'h0000_0000);
        wr(12'h340, 32'h0000_00AB);
        cycle();
        idle_inputs();
        rd_chk("trapwr.mscratch", 12'h340, 32'h0000_00AB, 1'b0);

        // Trap plus write to an unrelated CSR: the write commits
        exception_i = 1'b1; mepc_i = 32'h0000_0400; mcause_i = 32'd5;
        core_mode_i = 2'b11; wr(12'h305, 32'h0000_0047);
        cycle();
        idle_inputs();
        chk("trapmtvec.mtvec", mtvec_q_o, 32'h0000_0044);
        chk("trapmtvec.mepc", mepc_q_o, 32'h0000_0400);

        // Counter carry and half writes
        wr(12'hB80, 32'd0);
        cycle();
        wr(12'hB00, 32'hFFFF_FFFF);
        cycle();
        idle_inputs();
        rd_chk("cnt.lo_written", 12'hB00, 32'hFFFF_FFFF, 1'b0);
        cycle();
        rd_chk("cnt.wrap_lo", 12'hB00, 32'd0, 1'b0);
        rd_chk("cnt.carry_hi", 12'hB80, 32'd1, 1'b0);
        wr(12'hB80, 32'd7);
        cycle();
        idle_inputs();
        rd_chk("cnt.hi_written", 12'hB80, 32'd7, 1'b0);
        rd_chk("cnt.lo_held", 12'hB00, 32'd0, 1'b0);
        cycle();
        rd_chk("cnt.lo_resume", 12'hB00, 32'd1, 1'b0);
        retire_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        retire_i = 1'b0;
        rd_chk("cnt.minstret3", 12'hB02, 32'd3, 1'b0);

        // User counter alias and an unimplemented address
`ifdef ZICNTR_USER_EN
        rd_chk("alias.c00", 12'hC00, m_cyc[31:0], 1'b0);
`else
        rd_chk("alias.c00", 12'hC00, 32'd0, 1'b1);
`endif
        rd_chk("alias.7c0", 12'h7C0, 32'd0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if ($urandom_range(0, 1) == 1) begin
                csr_wbk_v_i = 1'b1;
                csr_adr_i   = adr_pool[$urandom_range(0, 19)];
                csr_data_i  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            exception_i = ($urandom_range(0, 7) == 0);
            mcause_i    = $urandom;
            mtval_i     = $urandom;
            mepc_i      = $urandom;
            core_mode_i = 2'($urandom_range(0, 3));
            retire_i    = 1'($urandom_range(0, 1));
            cycle();
            model_chk($sformatf("rnd%0d", i), adr_pool[$urandom_range(0, 19)]);
        end

        // Asynchronous reset mid-operation
        idle_inputs();
        wr(12'h340, 32'h5555_AAAA);
        #3;
        reset = 1'b1;
        m_reset();
        #1;
        chk("midrst.mstatus", mstatus_q_o, 32'h0000_1800);
        chk("midrst.mtvec", mtvec_q_o, 32'd0);
        chk("midrst.mepc", mepc_q_o, 32'd0);
        rd_chk("midrst.mcycle", 12'hB00, 32'd0, 1'b0);
        rd_chk("midrst.mscratch", 12'h340, 32'd0, 1'b0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rd_chk("midrst.restart", 12'hB00, 32'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
